// File: rtl/im_axi_read_slave_pkg.sv
// Shared types and constants for the instruction-SRAM AXI read responder.
// Optional feature macro: IM_WRAP_BURST_EN (enables legal WRAP bursts).
package im_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CAP  = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] LEGAL_SIZE = 3'b010;

`ifdef IM_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    // Response code is decided once at AR time and applies to every beat.
    function automatic logic [1:0] calc_resp(input logic       addr_hi_nz,
                                             input logic [2:0] size,
                                             input logic [1:0] burst,
                                             input logic [3:0] len);
        logic [1:0] resp;
        resp = RESP_OKAY;
        if (addr_hi_nz) begin
            resp = RESP_DECERR;
        end else if (size != LEGAL_SIZE) begin
            resp = RESP_SLVERR;
        end else if (burst == 2'b11) begin
            resp = RESP_SLVERR;
        end else if (burst == BURST_WRAP) begin
            if (!WRAP_EN) begin
                resp = RESP_SLVERR;
            end else if (!(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
                resp = RESP_SLVERR;
            end
        end
        return resp;
    endfunction

endpackage

// File: rtl/im_axi_read_slave_if.sv
// AXI read-channel (AR/R) bundle between the fetch interconnect and the IM responder.
// Valid/ready: a transfer happens on a rising edge where both VALID and READY are high;
// once VALID is raised the source holds the payload stable until that edge.
interface im_axi_read_slave_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;

    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/im_axi_read_slave_burst_addr_gen.sv
// Next word address within a burst: FIXED holds, INCR wraps at 2^ADDR_W,
// WRAP (only with IM_WRAP_BURST_EN) cycles inside an aligned ARLEN+1 block.
module im_burst_addr_gen
    import im_slave_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        burst_i,
    input  logic [3:0]        len_i,
    output logic [ADDR_W-1:0] next_addr_o
);
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] wrap_addr;

    always_comb begin
        incr_addr = addr_i + {{(ADDR_W-1){1'b0}}, 1'b1};
        // Legal wrap lengths are 2^n-1, so ARLEN itself is the low-bit mask.
        wrap_mask = {{(ADDR_W-4){1'b0}}, len_i};
        wrap_addr = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);

        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = incr_addr;
            BURST_WRAP: next_addr_o = WRAP_EN ? wrap_addr : addr_i;
            default:    next_addr_o = addr_i;
        endcase
    end
endmodule

// File: rtl/im_axi_read_slave.sv
// AXI read responder for the 16K x 32 instruction SRAM: one burst at a time,
// one beat per ADDR -> CAP -> DATA pass. WRAP support via IM_WRAP_BURST_EN.
module im_axi_read_slave
    import im_slave_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    im_axi_read_slave_if.slave axi,
    output logic              IM_CEB,
    output logic [ADDR_W-1:0] IM_A,
    input  logic [31:0]       IM_DO,
    output state_t            state_o
);
    state_t            state_q,   state_d;
    logic              arready_q, arready_d;
    logic [ID_W-1:0]   id_q,      id_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [3:0]        len_q,     len_d;
    logic [1:0]        burst_q,   burst_d;
    logic [1:0]        code_q,    code_d;
    logic [3:0]        cnt_q,     cnt_d;
    logic [31:0]       rdata_q,   rdata_d;

    logic [ADDR_W-1:0] next_addr;
    logic              is_last;
    logic              code_okay;
    logic              unused_ok;

    assign unused_ok = ^axi.ARADDR[1:0];
    assign is_last   = (cnt_q == len_q);
    assign code_okay = (code_q == RESP_OKAY);

    im_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .burst_i     (burst_q),
        .len_i       (len_q),
        .next_addr_o (next_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= BURST_FIXED;
            code_q    <= RESP_OKAY;
            cnt_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                // arready_q is only high in IDLE, and low in the first cycle out of reset.
                if (axi.ARVALID && arready_q) begin
                    id_d    = axi.ARID;
                    addr_d  = axi.ARADDR[ADDR_W+1:2];
                    len_d   = axi.ARLEN;
                    burst_d = axi.ARBURST;
                    code_d  = calc_resp(|axi.ARADDR[31:ADDR_W+2], axi.ARSIZE,
                                        axi.ARBURST, axi.ARLEN);
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                state_d = CAP;
            end
            CAP: begin
                rdata_d = code_okay ? IM_DO : 32'h0;
                state_d = DATA;
            end
            DATA: begin
                if (axi.RREADY) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = next_addr;
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ADDR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        arready_d = (state_d == IDLE);
    end

    assign axi.ARREADY = arready_q;
    assign axi.RVALID  = (state_q == DATA);
    assign axi.RLAST   = (state_q == DATA) && is_last;
    assign axi.RRESP   = (state_q == DATA) ? code_q : RESP_OKAY;
    assign axi.RDATA   = rdata_q;
    assign axi.RID     = id_q;

    // Error bursts never touch the SRAM.
    assign IM_CEB  = !((state_q == ADDR) && code_okay);
    assign IM_A    = addr_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_im_axi_read_slave.sv
// Directed bench for im_axi_read_slave with a simple registered SRAM model.
module tb_im_axi_read_slave;
    import im_slave_pkg::*;

    logic        clk;
    logic        rst;
    logic        im_ceb;
    logic [13:0] im_a;
    logic [31:0] im_do;
    state_t      dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [13:0] exp_a_q[$];
    logic [13:0] obs_a_q[$];

    im_axi_read_slave_if #(.ID_W(4)) axi ();

    im_axi_read_slave #(
        .ID_W   (4),
        .ADDR_W (14)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .axi     (axi),
        .IM_CEB  (im_ceb),
        .IM_A    (im_a),
        .IM_DO   (im_do),
        .state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data is a recognisable function of the word address.
    always @(posedge clk) begin
        if (!im_ceb) im_do <= 32'hC0DE_0000 | {18'b0, im_a};
        else         im_do <= 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (!im_ceb) obs_a_q.push_back(im_a);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] len);
        int waited;
        @(negedge clk);
        axi.ARID    = id;
        axi.ARADDR  = addr;
        axi.ARSIZE  = size;
        axi.ARBURST = burst;
        axi.ARLEN   = len;
        axi.ARVALID = 1'b1;
        waited = 0;
        while (!axi.ARREADY && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!axi.ARREADY) check("arready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        axi.ARVALID = 1'b0;
    endtask

    task automatic collect_beat(input string tag, input logic [3:0] id,
                                input logic [1:0] resp, input logic last);
        int cnt;
        logic [31:0] exp_d;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!axi.RVALID && cnt < 10);
        exp_d = exp_q.pop_front();
        check({tag, "_latency"}, cnt, 3);
        check({tag, "_rdata"}, axi.RDATA, exp_d);
        check({tag, "_rresp"}, {30'b0, axi.RRESP}, {30'b0, resp});
        check({tag, "_rid"}, {28'b0, axi.RID}, {28'b0, id});
        check({tag, "_rlast"}, {31'b0, axi.RLAST}, {31'b0, last});
    endtask

    task automatic check_addrs(input string tag);
        int n;
        n = exp_a_q.size();
        check({tag, "_sram_accesses"}, obs_a_q.size(), n);
        for (int i = 0; i < n && obs_a_q.size() > 0; i++)
            check({tag, "_im_a"}, {18'b0, obs_a_q.pop_front()}, {18'b0, exp_a_q.pop_front()});
        exp_a_q.delete();
        obs_a_q.delete();
    endtask

    task automatic run_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [3:0] len, input logic [1:0] resp);
        obs_a_q.delete();
        send_ar(id, addr, size, burst, len);
        for (int b = 0; b <= int'(len); b++)
            collect_beat(tag, id, resp, b == int'(len));
        @(negedge clk);
        check({tag, "_arready_after"}, {31'b0, axi.ARREADY}, 32'd1);
        check({tag, "_rvalid_after"}, {31'b0, axi.RVALID}, 32'd0);
        check_addrs(tag);
    endtask

    initial begin
        int rv_seen;
        rst         = 1'b1;
        axi.ARVALID = 1'b0;
        axi.ARID    = '0;
        axi.ARADDR  = '0;
        axi.ARLEN   = '0;
        axi.ARSIZE  = 3'b010;
        axi.ARBURST = BURST_INCR;
        axi.RREADY  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", {31'b0, axi.ARREADY}, 32'd0);
        check("rst_rvalid", {31'b0, axi.RVALID}, 32'd0);
        check("rst_rlast", {31'b0, axi.RLAST}, 32'd0);
        check("rst_rid", {28'b0, axi.RID}, 32'd0);
        check("rst_rdata", axi.RDATA, 32'd0);
        check("rst_rresp", {30'b0, axi.RRESP}, 32'd0);
        check("rst_im_ceb", {31'b0, im_ceb}, 32'd1);
        check("rst_im_a", {18'b0, im_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_arready", {31'b0, axi.ARREADY}, 32'd1);

        // INCR, 4 beats from word 0x40
        exp_a_q = '{14'h40, 14'h41, 14'h42, 14'h43};
        exp_q   = '{32'hC0DE0040, 32'hC0DE0041, 32'hC0DE0042, 32'hC0DE0043};
        run_burst("incr4", 4'h3, 32'h0000_0100, 3'b010, BURST_INCR, 4'd3, RESP_OKAY);

        // INCR wrapping at the top of the SRAM
        exp_a_q = '{14'h3FFF, 14'h0000};
        exp_q   = '{32'hC0DE3FFF, 32'hC0DE0000};
        run_burst("incr_top", 4'hA, 32'h0000_FFFC, 3'b010, BURST_INCR, 4'd1, RESP_OKAY);

        // FIXED holds the address
        exp_a_q = '{14'h10, 14'h10, 14'h10};
        exp_q   = '{32'hC0DE0010, 32'hC0DE0010, 32'hC0DE0010};
        run_burst("fixed", 4'h5, 32'h0000_0040, 3'b010, BURST_FIXED, 4'd2, RESP_OKAY);

        // Out of range -> DECERR, no SRAM access
        exp_a_q.delete();
        exp_q = '{32'h0, 32'h0, 32'h0};
        run_burst("decerr", 4'h6, 32'h0001_0000, 3'b010, BURST_INCR, 4'd2, RESP_DECERR);

        // Bad size -> SLVERR single beat
        exp_a_q.delete();
        exp_q = '{32'h0};
        run_burst("bad_size", 4'h7, 32'h0000_0020, 3'b001, BURST_INCR, 4'd0, RESP_SLVERR);

        // Reserved burst type -> SLVERR
        exp_a_q.delete();
        exp_q = '{32'h0, 32'h0};
        run_burst("bad_burst", 4'h8, 32'h0000_0020, 3'b010, 2'b11, 4'd1, RESP_SLVERR);

`ifdef IM_WRAP_BURST_EN
        exp_a_q = '{14'h6, 14'h7, 14'h4, 14'h5};
        exp_q   = '{32'hC0DE0006, 32'hC0DE0007, 32'hC0DE0004, 32'hC0DE0005};
        run_burst("wrap4", 4'hB, 32'h0000_0018, 3'b010, BURST_WRAP, 4'd3, RESP_OKAY);
        exp_a_q.delete();
        exp_q = '{32'h0, 32'h0, 32'h0};
        run_burst("wrap_badlen", 4'hC, 32'h0000_0018, 3'b010, BURST_WRAP, 4'd2, RESP_SLVERR);
`else
        exp_a_q.delete();
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0};
        run_burst("wrap4", 4'hB, 32'h0000_0018, 3'b010, BURST_WRAP, 4'd3, RESP_SLVERR);
`endif

        // Stall on beat 2, then reset mid-burst
        obs_a_q.delete();
        exp_q = '{32'hC0DE0080, 32'hC0DE0081};
        send_ar(4'h9, 32'h0000_0200, 3'b010, BURST_INCR, 4'd3);
        collect_beat("stall_b1", 4'h9, RESP_OKAY, 1'b0);
        @(posedge clk);
        #1;
        axi.RREADY = 1'b0;
        collect_beat("stall_b2", 4'h9, RESP_OKAY, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_rvalid", {31'b0, axi.RVALID}, 32'd1);
            check("stall_rdata", axi.RDATA, 32'hC0DE0081);
            check("stall_rid", {28'b0, axi.RID}, 32'h9);
            check("stall_rresp", {30'b0, axi.RRESP}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rvalid", {31'b0, axi.RVALID}, 32'd0);
        check("midrst_arready", {31'b0, axi.ARREADY}, 32'd0);
        check("midrst_rid", {28'b0, axi.RID}, 32'd0);
        check("midrst_rdata", axi.RDATA, 32'd0);
        check("midrst_rresp", {30'b0, axi.RRESP}, 32'd0);
        check("midrst_rlast", {31'b0, axi.RLAST}, 32'd0);
        check("midrst_im_ceb", {31'b0, im_ceb}, 32'd1);
        check("midrst_im_a", {18'b0, im_a}, 32'd0);
        rst        = 1'b0;
        axi.RREADY = 1'b1;
        @(negedge clk);
        check("after_rst_arready", {31'b0, axi.ARREADY}, 32'd1);
        check("after_rst_rvalid", {31'b0, axi.RVALID}, 32'd0);
        rv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (axi.RVALID) rv_seen++;
        end
        check("no_beats_after_rst", rv_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/im_axi_read_slave.md
# im_axi_read_slave

AXI read-channel responder (AR/R only) that fronts the 16K-word instruction SRAM. The CPU fetch path issues word-aligned reads through the AXI interconnect; this block accepts each AR request, steps through the burst, reads the SRAM, and returns R beats. It is the memory end of the instruction-fetch path whose 14-bit word address space this block implements.

## Interface
Parameters:
- ID_W, 4, width of ARID/RID
- ADDR_W, 14, SRAM word-address width (16K x 32)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ARID  in  ID_W  request ID
- ARADDR  in  32  byte address
- ARLEN  in  4  beats minus one (1..16 beats)
- ARSIZE  in  3  beat size; only 3'b010 (4 bytes) is legal
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
- ARVALID  in  1  request valid
- ARREADY  out  1  request accepted when high with ARVALID
- RID  out  ID_W  echoes the captured ARID
- RDATA  out  32  read data
- RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- RLAST  out  1  final beat
- RVALID  out  1  beat valid
- RREADY  in  1  master accepts beat
- IM_CEB  out  1  SRAM chip enable, active low
- IM_A  out  ADDR_W  SRAM word address
- IM_DO  in  32  SRAM data out, valid the cycle after IM_CEB low

## Operation
- FSM states: IDLE, ADDR, CAP, DATA.
- IDLE: ARREADY=1. On ARVALID: capture ARID, word address ARADDR[15:2], ARLEN, ARBURST, and the response code; beat count=0; go to ADDR.
- Response code, fixed per burst: ARADDR[31:16]!=0 -> DECERR; else ARSIZE!=3'b010 or illegal burst (ARBURST=11, or WRAP rejected, see Configuration) -> SLVERR; else OKAY.
- ADDR: IM_CEB=0 and IM_A=current address only when the code is OKAY; otherwise IM_CEB stays 1. Go to CAP.
- CAP: rdata_q <= IM_DO if OKAY, else 0. Go to DATA.
- DATA: RVALID=1, RDATA=rdata_q, RRESP=code, RLAST=(count==len). If RREADY and not last: advance the address, count+1, go to ADDR. If RREADY and last: go to IDLE. If RREADY=0, all R outputs hold stable.
- Address advance: FIXED keeps the address. INCR adds 1, modulo 2^ADDR_W (0x3FFF -> 0x0000). WRAP: see Configuration.
- An error burst still returns exactly ARLEN+1 beats, every beat carrying the error code and RDATA=0.

## Timing
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=00, IM_CEB=1, IM_A=0. State is IDLE; ARREADY=1 from the first cycle after rst deasserts.
- AR handshake at edge N -> ADDR in N+1, CAP in N+2, RVALID high in N+3.
- With RREADY held high, one beat every 3 cycles. ARREADY=0 from the edge after the handshake until the state returns to IDLE.
- No outstanding transactions beyond one: only one burst is in flight.
- rst asserted mid-burst: at the next edge all outputs take their reset values. The burst is abandoned and no further R beats are sent.

## Configuration
- IM_WRAP_BURST_EN defined: WRAP is legal for ARLEN in {1,3,7,15}. The address wraps within an aligned block of ARLEN+1 words: low bits increment, high bits are held. WRAP with any other ARLEN -> SLVERR.
- Not defined: every WRAP request -> SLVERR for all beats, with no SRAM access.

## Structure
- Package im_slave_pkg holds: the state enum (IDLE, ADDR, CAP, DATA); the RESP_OKAY/SLVERR/DECERR constants; the BURST_FIXED/INCR/WRAP constants; and LEGAL_SIZE=3'b010.
- One sub-module, im_burst_addr_gen: combinational next-address calculation from the current address, burst type, and length, including the wrap mask under IM_WRAP_BURST_EN.

## Test plan
- INCR, ARADDR=0x0000_0100, ARLEN=3, RREADY=1 -> IM_A sequence 0x40, 0x41, 0x42, 0x43; 4 OKAY beats with SRAM data; RLAST only on beat 4; first RVALID 3 cycles after the handshake.
- INCR at ARADDR=0x0000_FFFC, ARLEN=1 -> IM_A 0x3FFF then 0x0000.
- ARADDR=0x0001_0000, ARLEN=2 -> 3 beats, RRESP=11, RDATA=0, IM_CEB never low.
- ARSIZE=3'b001, ARLEN=0 -> 1 beat, RRESP=10, RLAST=1.
- WRAP, ARADDR=0x0000_0018, ARLEN=3 -> with the macro defined, IM_A is 0x6, 0x7, 0x4, 0x5; without it, 4 SLVERR beats.
- RREADY low for 5 cycles during beat 2, then rst asserted for one cycle -> RDATA/RID/RRESP stable while stalled; after reset, RVALID=0 and ARREADY=1 the following cycle.
